// File: rtl/mw_seg_pkg.sv
// mw_seg_pkg: shared types and helpers for the MW segment (access size, byte enables, load extension).
// Latency: combinational helpers only.
// Backpressure: none; pure functions.
package mw_seg_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10,
      MEM_D = 2'b11
   } mem_size_t;

   // Helpers work at the widest supported data width (64 bits, 8 lanes);
   // callers truncate the result to their own XLEN / BE_W.
   localparam int MAX_XLEN = 64;
   localparam int MAX_BE   = 8;

   // Byte-lane mask for a store; the shift truncates to the 8-bit lane field.
   function automatic logic [MAX_BE-1:0] byte_en(mem_size_t size, logic [2:0] off);
      logic [MAX_BE-1:0] be;
      case (size)
         MEM_B:   be = 8'h01 << off;
         MEM_H:   be = 8'h03 << off;
         MEM_W:   be = 8'h0F << off;
         default: be = 8'hFF;
      endcase
      return be;
   endfunction

   // Shift the raw RAM word down to the accessed byte, mask to size, then extend.
   function automatic logic [MAX_XLEN-1:0] load_ext(logic [MAX_XLEN-1:0] raw, mem_size_t size,
                                                    logic [2:0] off, logic uns);
      logic [MAX_XLEN-1:0] sh;
      logic [MAX_XLEN-1:0] res;
      sh = raw >> {off, 3'b000};
      case (size)
         MEM_B:   res = uns ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
         MEM_H:   res = uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
         MEM_W:   res = uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

   // Natural-alignment check for the given access size.
   function automatic logic misaligned(mem_size_t size, logic [2:0] off);
      logic m;
      case (size)
         MEM_H:   m = off[0];
         MEM_W:   m = (off[1:0] != 2'b00);
         MEM_D:   m = (off != 3'b000);
         default: m = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mw_seg_param_data_ram_dp.sv
// data_ram_dp: true dual-port RAM, per-byte write enables, read enable on port A, no reset.
// Latency: one-cycle synchronous read on both ports, read-first on a same-address write.
// Backpressure: none; port A output holds while ena=0, port B runs every cycle.
module data_ram_dp #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 12
) (
   input  logic                clk,
   input  logic                ena,
   input  logic [XLEN/8-1:0]   wea,
   input  logic [ADDR_W-1:0]   addra,
   input  logic [XLEN-1:0]     dina,
   output logic [XLEN-1:0]     douta,
   input  logic [XLEN/8-1:0]   web,
   input  logic [ADDR_W-1:0]   addrb,
   input  logic [XLEN-1:0]     dinb,
   output logic [XLEN-1:0]     doutb
);

   localparam int BE_W = XLEN / 8;

   logic [XLEN-1:0] mem [0:(2**ADDR_W)-1];

   // Both ports share one process: reads sample the old word, then enabled byte lanes are written.
   always_ff @(posedge clk) begin
      if (ena) begin
         douta <= mem[addra];
      end
      doutb <= mem[addrb];
      for (int b = 0; b < BE_W; b++) begin
         if (wea[b]) begin
            mem[addra][8*b +: 8] <= dina[8*b +: 8];
         end
         if (web[b]) begin
            mem[addrb][8*b +: 8] <= dinb[8*b +: 8];
         end
      end
   end

endmodule

// File: rtl/mw_seg_param.sv
// mw_seg_param: EX->MW segment register owning the byte-writable dual-port data RAM; MW_SEG_MISALIGN_TRAP_EN enables the misalignment trap.
// Latency: one cycle EX->MW for every field including aligned/extended load data; debug read one cycle.
// Backpressure: en=0 stalls and holds every output bit-stable; clear (with en=1) captures a bubble.
module mw_seg_param
   import mw_seg_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 12,
   parameter int RD_W   = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clear,
   input  logic [XLEN-1:0]   alu_out_e,
   input  logic [XLEN-1:0]   store_data_e,
   input  logic [1:0]        mem_size_e,
   input  logic              mem_write_e,
   input  logic              mem_read_e,
   input  logic              load_unsigned_e,
   input  logic [RD_W-1:0]   rd_e,
   input  logic              reg_write_e,
   input  logic              load_npc_e,
   input  logic [XLEN-1:0]   pc_e,
   output logic [XLEN-1:0]   alu_out_mw,
   output logic [XLEN-1:0]   pc_mw,
   output logic [RD_W-1:0]   rd_mw,
   output logic              reg_write_mw,
   output logic              mem_to_reg_mw,
   output logic              load_npc_mw,
   output logic [XLEN-1:0]   load_data_mw,
   output logic              misalign_mw,
   input  logic [XLEN-1:0]   dbg_addr,
   input  logic [XLEN-1:0]   dbg_wdata,
   input  logic [XLEN/8-1:0] dbg_we,
   output logic [XLEN-1:0]   dbg_rdata
);

   localparam int OFF_W = $clog2(XLEN / 8);
   localparam int BE_W  = XLEN / 8;

   logic [ADDR_W-1:0] word_idx;
   logic [OFF_W-1:0]  off;
   logic [2:0]        off3;
   mem_size_t         size_eff;
   logic              mis_e;
   logic              commit;
   logic [MAX_BE-1:0] be_full;
   logic [BE_W-1:0]   we_a;
   logic [XLEN-1:0]   wdata_a;
   logic [XLEN-1:0]   douta;

   logic [OFF_W-1:0]  off_mw;
   mem_size_t         size_mw;
   logic              uns_mw;
   logic              clr_mw;
   logic              mis_mw;
   logic              kill_mw;   // set by reset, so stale RAM output never leaks out before the first read

   logic [2:0]            off_mw3;
   logic [MAX_XLEN-1:0]   raw64;
   logic [MAX_XLEN-1:0]   ext64;
   logic                  unused;

   assign word_idx = alu_out_e[ADDR_W+OFF_W-1:OFF_W];
   assign off      = alu_out_e[OFF_W-1:0];

   // Address decode: widen offset, fold dword onto word for 32-bit builds, build lane mask and store data.
   always_comb begin
      off3 = 3'b000;
      off3[OFF_W-1:0] = off;
      size_eff = mem_size_t'(mem_size_e);
      if (XLEN == 32 && size_eff == MEM_D) begin
         size_eff = MEM_W;
      end
      be_full = byte_en(size_eff, off3);
      we_a    = be_full[BE_W-1:0] & {BE_W{commit}};
      wdata_a = store_data_e << {off, 3'b000};
   end

`ifdef MW_SEG_MISALIGN_TRAP_EN
   assign mis_e = (mem_read_e | mem_write_e) & misaligned(size_eff, off3);
`else
   assign mis_e = 1'b0;
`endif

   assign commit = rst_n & en & ~clear & mem_write_e & ~mis_e;

   data_ram_dp #(
      .XLEN   (XLEN),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .ena   (en),
      .wea   (we_a),
      .addra (word_idx),
      .dina  (wdata_a),
      .douta (douta),
      .web   (dbg_we),
      .addrb (dbg_addr[ADDR_W+OFF_W-1:OFF_W]),
      .dinb  (dbg_wdata),
      .doutb (dbg_rdata)
   );

   // Stage register: reset zeroes, stall holds, flush loads a bubble, otherwise capture EX.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_out_mw    <= '0;
         pc_mw         <= '0;
         rd_mw         <= '0;
         reg_write_mw  <= 1'b0;
         mem_to_reg_mw <= 1'b0;
         load_npc_mw   <= 1'b0;
         off_mw        <= '0;
         size_mw       <= MEM_B;
         uns_mw        <= 1'b0;
         clr_mw        <= 1'b0;
         mis_mw        <= 1'b0;
         kill_mw       <= 1'b1;
      end else if (en) begin
         kill_mw <= 1'b0;
         if (clear) begin
            alu_out_mw    <= '0;
            pc_mw         <= '0;
            rd_mw         <= '0;
            reg_write_mw  <= 1'b0;
            mem_to_reg_mw <= 1'b0;
            load_npc_mw   <= 1'b0;
            off_mw        <= '0;
            size_mw       <= MEM_B;
            uns_mw        <= 1'b0;
            clr_mw        <= 1'b1;
            mis_mw        <= 1'b0;
         end else begin
            alu_out_mw    <= alu_out_e;
            pc_mw         <= pc_e;
            rd_mw         <= rd_e;
            reg_write_mw  <= reg_write_e;
            mem_to_reg_mw <= mem_read_e;
            load_npc_mw   <= load_npc_e;
            off_mw        <= off;
            size_mw       <= size_eff;
            uns_mw        <= load_unsigned_e;
            clr_mw        <= 1'b0;
            mis_mw        <= mis_e;
         end
      end
   end

   assign misalign_mw = mis_mw;

   // Load path: align and extend the held RAM word; bubbles, reset and trapped accesses read as zero.
   always_comb begin
      off_mw3 = 3'b000;
      off_mw3[OFF_W-1:0] = off_mw;
      raw64 = '0;
      raw64[XLEN-1:0] = douta;
      ext64 = load_ext(raw64, size_mw, off_mw3, uns_mw);
      load_data_mw = ext64[XLEN-1:0];
      if (clr_mw | kill_mw | mis_mw) begin
         load_data_mw = '0;
      end
   end

   assign unused = ^{alu_out_e, dbg_addr, ext64};

endmodule

// File: tb/tb_mw_seg_param.sv
// tb_mw_seg_param: table vectors, directed corner sequences and random traffic against a byte-array model.
// Latency: model predicts every MW output one cycle after the inputs are applied.
// Backpressure: random stall, flush and reset are exercised alongside the debug port.
module tb_mw_seg_param;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 12;
   localparam int RD_W   = 5;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic              clear;
   logic [XLEN-1:0]   alu_out_e;
   logic [XLEN-1:0]   store_data_e;
   logic [1:0]        mem_size_e;
   logic              mem_write_e;
   logic              mem_read_e;
   logic              load_unsigned_e;
   logic [RD_W-1:0]   rd_e;
   logic              reg_write_e;
   logic              load_npc_e;
   logic [XLEN-1:0]   pc_e;
   logic [XLEN-1:0]   alu_out_mw;
   logic [XLEN-1:0]   pc_mw;
   logic [RD_W-1:0]   rd_mw;
   logic              reg_write_mw;
   logic              mem_to_reg_mw;
   logic              load_npc_mw;
   logic [XLEN-1:0]   load_data_mw;
   logic              misalign_mw;
   logic [XLEN-1:0]   dbg_addr;
   logic [XLEN-1:0]   dbg_wdata;
   logic [XLEN/8-1:0] dbg_we;
   logic [XLEN-1:0]   dbg_rdata;

   always #5 clk = ~clk;

   mw_seg_param #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RD_W(RD_W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
      .alu_out_e(alu_out_e), .store_data_e(store_data_e), .mem_size_e(mem_size_e),
      .mem_write_e(mem_write_e), .mem_read_e(mem_read_e), .load_unsigned_e(load_unsigned_e),
      .rd_e(rd_e), .reg_write_e(reg_write_e), .load_npc_e(load_npc_e), .pc_e(pc_e),
      .alu_out_mw(alu_out_mw), .pc_mw(pc_mw), .rd_mw(rd_mw), .reg_write_mw(reg_write_mw),
      .mem_to_reg_mw(mem_to_reg_mw), .load_npc_mw(load_npc_mw), .load_data_mw(load_data_mw),
      .misalign_mw(misalign_mw), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_we(dbg_we), .dbg_rdata(dbg_rdata)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: memory as a flat byte array (first 1 KiB only is used), plus expected outputs.
   logic [7:0]  mm [0:1023];
   logic [31:0] e_alu, e_pc, e_ld, e_dbg;
   logic [4:0]  e_rd;
   logic        e_rw, e_m2r, e_npc, e_mis;
   logic        dbg_ok;

   typedef struct {
      logic        en;
      logic        clr;
      logic        wr;
      logic        rd;
      logic        uns;
      logic [1:0]  sz;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_ld;
   } vec_t;

   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int size_bytes(input logic [1:0] s);
      if (s == 2'b00) return 1;
      if (s == 2'b01) return 2;
      return 4;
   endfunction

   // Model of one clock edge, evaluated from the inputs as they stand at that edge.
   task automatic model_edge();
      int n, o, base, db;
      logic mis;
      logic [31:0] v;
      n    = size_bytes(mem_size_e);
      o    = int'(alu_out_e[1:0]);
      base = int'(alu_out_e[9:0]) - o;
      db   = int'(dbg_addr[9:2]) * 4;
      mis  = 1'b0;
`ifdef MW_SEG_MISALIGN_TRAP_EN
      mis = (mem_read_e || mem_write_e) && ((o % n) != 0);
`endif
      e_dbg = {mm[db+3], mm[db+2], mm[db+1], mm[db]};
      if (!rst_n) begin
         e_alu = 0; e_pc = 0; e_rd = 0; e_rw = 0; e_m2r = 0; e_npc = 0; e_ld = 0; e_mis = 0;
      end else if (en) begin
         if (clear) begin
            e_alu = 0; e_pc = 0; e_rd = 0; e_rw = 0; e_m2r = 0; e_npc = 0; e_ld = 0; e_mis = 0;
         end else begin
            e_alu = alu_out_e; e_pc = pc_e; e_rd = rd_e; e_rw = reg_write_e;
            e_m2r = mem_read_e; e_npc = load_npc_e; e_mis = mis;
            v = 0;
            for (int k = 0; k < n; k++) begin
               if (o + k < 4) v = v | (32'(mm[base+o+k]) << (8*k));
            end
            if (!load_unsigned_e && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            e_ld = mis ? 32'h0 : v;
         end
      end
      if (rst_n && en && !clear && mem_write_e && !mis) begin
         for (int k = 0; k < n; k++) begin
            if (o + k < 4) mm[base+o+k] = store_data_e[8*k +: 8];
         end
      end
      for (int b = 0; b < 4; b++) begin
         if (dbg_we[b]) mm[db+b] = dbg_wdata[8*b +: 8];
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("alu_out_mw", alu_out_mw, e_alu);
      chk("pc_mw", pc_mw, e_pc);
      chk("rd_mw", 32'(rd_mw), 32'(e_rd));
      chk("reg_write_mw", 32'(reg_write_mw), 32'(e_rw));
      chk("mem_to_reg_mw", 32'(mem_to_reg_mw), 32'(e_m2r));
      chk("load_npc_mw", 32'(load_npc_mw), 32'(e_npc));
      chk("load_data_mw", load_data_mw, e_ld);
      chk("misalign_mw", 32'(misalign_mw), 32'(e_mis));
      if (dbg_ok) chk("dbg_rdata", dbg_rdata, e_dbg);
   endtask

   task automatic drive(input logic en_i, input logic clr_i, input logic [1:0] sz,
                        input logic wr, input logic rd, input logic uns,
                        input logic [31:0] addr, input logic [31:0] data);
      en = en_i; clear = clr_i; mem_size_e = sz; mem_write_e = wr; mem_read_e = rd;
      load_unsigned_e = uns; alu_out_e = addr; store_data_e = data;
      rd_e = 5'($urandom); pc_e = $urandom; reg_write_e = 1'($urandom); load_npc_e = 1'($urandom);
      dbg_we = 4'h0;
   endtask

   initial begin
      // en clr wr rd uns sz addr data exp_ld
      tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h10, 32'h1122_3344, 32'h0000_0000};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h13, 32'h0,         32'h0000_0011};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h14, 32'h0000_0080, 32'h0000_0000};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h14, 32'h0,         32'hFFFF_FF80};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h12, 32'h0,         32'h0000_1122};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 32'h12, 32'h0,         32'h0000_1122};
      tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h21, 32'h0000_00AB, 32'h0000_0000};
      tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h20, 32'h0,         32'h0000_AB00};
      tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h14, 32'h0,         32'h0000_0080};
      tbl[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 32'h10, 32'h0,         32'h0000_3344};

      for (int i = 0; i < 1024; i++) mm[i] = 8'h00;
      e_alu = 0; e_pc = 0; e_rd = 0; e_rw = 0; e_m2r = 0; e_npc = 0; e_ld = 0; e_mis = 0; e_dbg = 0;
      dbg_ok = 1'b0;

      // Hold reset while zero-filling the used RAM region through the debug port.
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      dbg_wdata = 32'h0;
      for (int w = 0; w < 256; w++) begin
         dbg_addr = 32'(w * 4);
         dbg_we   = 4'hF;
         cycle();
      end
      dbg_we = 4'h0;
      dbg_addr = 32'h0;
      cycle();
      dbg_ok = 1'b1;
      chk("reset_load_data", load_data_mw, 32'h0);
      chk("reset_alu_out", alu_out_mw, 32'h0);
      rst_n = 1'b1;

      // Table vectors.
      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].en, tbl[i].clr, tbl[i].sz, tbl[i].wr, tbl[i].rd, tbl[i].uns,
               tbl[i].addr, tbl[i].data);
         cycle();
         chk($sformatf("tbl%0d_load", i), load_data_mw, tbl[i].exp_ld);
      end

      // Stall holds load data while the debug port rewrites the same word.
      drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      cycle();
      chk("stall_load0", load_data_mw, 32'h1122_3344);
      drive(1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0);
      dbg_addr = 32'h10; dbg_wdata = 32'hDEAD_BEEF; dbg_we = 4'hF;
      for (int s = 0; s < 3; s++) begin
         cycle();
         chk("stall_hold", load_data_mw, 32'h1122_3344);
         chk("stall_alu_hold", alu_out_mw, 32'h10);
         dbg_we = 4'h0;
      end
      dbg_wdata = 32'h1122_3344; dbg_we = 4'hF;
      cycle();
      dbg_we = 4'h0; dbg_addr = 32'h20;
      cycle();
      chk("dbg_read_sb", dbg_rdata, 32'h0000_AB00);

      // Flush: store suppressed, outputs zero; then stall with clear holds.
      drive(1'b1, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0000_0055);
      reg_write_e = 1'b1;
      cycle();
      chk("flush_alu", alu_out_mw, 32'h0);
      chk("flush_rw", 32'(reg_write_mw), 32'h0);
      chk("flush_ld", load_data_mw, 32'h0);
      drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      cycle();
      chk("flush_ram_kept", load_data_mw, 32'h1122_3344);
      drive(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0);
      cycle();
      chk("stall_beats_clear_ld", load_data_mw, 32'h1122_3344);
      chk("stall_beats_clear_alu", alu_out_mw, 32'h10);

      // Reset during a store drops it.
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0000_0099);
      cycle();
      chk("rst_ld", load_data_mw, 32'h0);
      chk("rst_m2r", 32'(mem_to_reg_mw), 32'h0);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      cycle();
      chk("rst_store_dropped", load_data_mw, 32'h1122_3344);

      // Misaligned half store at 0x11.
      drive(1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 32'h11, 32'h0000_BEEF);
      cycle();
`ifdef MW_SEG_MISALIGN_TRAP_EN
      chk("mis_flag", 32'(misalign_mw), 32'h1);
`else
      chk("mis_flag", 32'(misalign_mw), 32'h0);
`endif
      drive(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      cycle();
`ifdef MW_SEG_MISALIGN_TRAP_EN
      chk("mis_mem", load_data_mw, 32'h1122_3344);
`else
      chk("mis_mem", load_data_mw, 32'h11BE_EF44);
`endif

      // Random traffic against the model; debug writes stay in the upper half of the region.
      for (int r = 0; r < 3000; r++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), 2'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom),
               32'($urandom_range(0, 511)), $urandom);
         dbg_wdata = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            dbg_we   = 4'($urandom);
            dbg_addr = 32'($urandom_range(512, 1023));
         end else begin
            dbg_we   = 4'h0;
            dbg_addr = 32'($urandom_range(0, 1023));
         end
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
